// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode values and datapath mux encodings.
// Optional feature macro: MIPS_MC_BNE_EN (adds the BNE state; the encoding is always reserved).
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        BNE    = 4'd12,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States in which the memory handshake is live and mem_ready matters.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the
// IR / memory / datapath side (slave).
// Optional feature macro: MIPS_MC_BNE_EN (adds BranchNe).
interface mips_multicycle_ctrl_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] Opcode;
    logic                mem_ready;
    logic                mem_req;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                Branch;
    logic [1:0]          PCSrc;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                RegWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic [3:0]          state_o;
    logic                illegal_op;
    logic                timeout;
`ifdef MIPS_MC_BNE_EN
    logic                BranchNe;
`endif

    modport master (
`ifdef MIPS_MC_BNE_EN
        output BranchNe,
`endif
        input  Opcode, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg,
               state_o, illegal_op, timeout
    );

    modport slave (
`ifdef MIPS_MC_BNE_EN
        input  BranchNe,
`endif
        output Opcode, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg,
               state_o, illegal_op, timeout
    );
endinterface

// File: rtl/mips_mc_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles of one access and
// flags the cycle in which the count would reach MEM_TIMEOUT.
// MEM_TIMEOUT must be >= 1 and 2**CNT_W must exceed MEM_TIMEOUT.
module mips_mc_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic in_mem,
    input  logic mem_ready,
    output logic expired
);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;

    // Held at zero outside memory states so every access starts from zero;
    // a ready cycle ends the access and clears it too.
    always_ff @(posedge clock) begin
        if (reset || !in_mem || mem_ready) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // This wait cycle is the one that brings the count to MEM_TIMEOUT;
    // a ready in the same cycle wins.
    assign expired = in_mem && !mem_ready && (cnt_reg == LIMIT);
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with a bounded memory handshake and
// sticky illegal-opcode / timeout flags that park the FSM in HALT.
// Optional feature macro: MIPS_MC_BNE_EN (bne via state BNE and BranchNe).
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    state_t state_reg;
    logic   illegal_op_reg;
    logic   timeout_reg;
    logic   in_mem;
    logic   wait_expired;

    assign in_mem = is_mem_state(state_reg);

    mips_mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .in_mem    (in_mem),
        .mem_ready (bus.mem_ready),
        .expired   (wait_expired)
    );

    // State sequencing and sticky fault flags; HALT is left only via reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= FETCH;
            illegal_op_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FETCH, MEMRD, MEMWR: begin
                    if (bus.mem_ready) begin
                        case (state_reg)
                            FETCH:   state_reg <= DECODE;
                            MEMRD:   state_reg <= MEMWB;
                            default: state_reg <= FETCH;
                        endcase
                    end else if (wait_expired) begin
                        state_reg   <= HALT;
                        timeout_reg <= 1'b1;
                    end
                end
                DECODE: begin
                    case (bus.Opcode)
                        OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state_reg <= MEMADR;
                        OPCODE_W'(OP_RTYPE):                state_reg <= EXEC;
                        OPCODE_W'(OP_BEQ):                  state_reg <= BRANCH;
                        OPCODE_W'(OP_ADDI):                 state_reg <= ADDIEX;
                        OPCODE_W'(OP_J):                    state_reg <= JUMP;
`ifdef MIPS_MC_BNE_EN
                        OPCODE_W'(OP_BNE):                  state_reg <= BNE;
`endif
                        default: begin
                            state_reg      <= HALT;
                            illegal_op_reg <= 1'b1;
                        end
                    endcase
                end
                MEMADR:  state_reg <= (bus.Opcode == OPCODE_W'(OP_SW)) ? MEMWR : MEMRD;
                EXEC:    state_reg <= ALUWB;
                ADDIEX:  state_reg <= ADDIWB;
                MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_reg <= FETCH;
`ifdef MIPS_MC_BNE_EN
                BNE:     state_reg <= FETCH;
`endif
                HALT:    state_reg <= HALT;
                default: state_reg <= HALT;
            endcase
        end
    end

    // Control decode from the state register; only the fetch/write strobes
    // are qualified by mem_ready so they fire once, on the completing cycle.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.Branch   = 1'b0;
        bus.PCSrc    = PCSRC_ALU;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = SRCB_REGB;
        bus.ALUOp    = ALUOP_W'(ALUOP_ADD);
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
`ifdef MIPS_MC_BNE_EN
        bus.BranchNe = 1'b0;
`endif
        case (state_reg)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            DECODE: bus.ALUSrcB = SRCB_IMMSH;
            MEMADR, ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemWrite = bus.mem_ready;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_W'(ALUOP_FUNCT);
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_W'(ALUOP_SUB);
                bus.Branch  = 1'b1;
                bus.PCSrc   = PCSRC_ALUOUT;
            end
`ifdef MIPS_MC_BNE_EN
            BNE: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALUOP_W'(ALUOP_SUB);
                bus.Branch   = 1'b1;
                bus.PCSrc    = PCSRC_ALUOUT;
                bus.BranchNe = 1'b1;
            end
`endif
            ADDIWB: bus.RegWrite = 1'b1;
            JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.state_o    = state_reg;
    assign bus.illegal_op = illegal_op_reg;
    assign bus.timeout    = timeout_reg;
endmodule
